// File: rtl/down_count_timer.sv
// MM:SS BCD countdown timer: loads a clamped preset, decrements once per TICK_DIV
// cycles while running, and flags expiry when the count reaches 00:00.
module down_count_timer #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        setTime,
    input  logic        startStop,
    input  logic        clear,
    input  logic [15:0] presetBcd,
    output logic [15:0] timeBcd,
    output logic        running,
    output logic        expired,
    output logic        expiredPulse
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [15:0]       time_q, time_d;
    logic              pulse_q, pulse_d;
    logic              tick;
    logic [15:0]       time_dec;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] p);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = p;
        if (mt > 4'd9) mt = 4'd9;
        if (mo > 4'd9) mo = 4'd9;
        if (st > 4'd5) st = 4'd5;
        if (so > 4'd9) so = 4'd9;
        return {mt, mo, st, so};
    endfunction

    // Ripple borrow through the four digits; 00:00 never wraps.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        logic       b;
        {mt, mo, st, so} = t;
        if (t == 16'h0000) return 16'h0000;
        if (so == 4'd0) begin so = 4'd9; b = 1'b1; end
        else begin so = so - 4'd1; b = 1'b0; end
        if (b) begin
            if (st == 4'd0) st = 4'd5;
            else begin st = st - 4'd1; b = 1'b0; end
        end
        if (b) begin
            if (mo == 4'd0) mo = 4'd9;
            else begin mo = mo - 4'd1; b = 1'b0; end
        end
        if (b) mt = mt - 4'd1;
        return {mt, mo, st, so};
    endfunction

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        time_d   = time_q;
        tick     = (state_q == RUN) && (div_q == DIV_LAST);
        time_dec = bcd_dec(time_q);
        if (clear) begin
            state_d = IDLE;
            time_d  = 16'h0000;
            div_d   = '0;
        end else if (setTime && (state_q != RUN)) begin
            state_d = IDLE;
            time_d  = clamp_bcd(presetBcd);
            div_d   = '0;
        end else if (startStop) begin
            // Pausing leaves div_q untouched so the partial second survives.
            case (state_q)
                IDLE: begin
                    if (time_q != 16'h0000) begin
                        state_d = RUN;
                        div_d   = '0;
                    end
                end
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (state_q == RUN) begin
            if (tick) begin
                div_d  = '0;
                time_d = time_dec;
                if (time_dec == 16'h0000) state_d = DONE;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        pulse_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            time_q  <= 16'h0000;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            time_q  <= time_d;
            pulse_q <= pulse_d;
        end
    end

    assign timeBcd      = time_q;
    assign running      = (state_q == RUN);
    assign expired      = (state_q == DONE);
    assign expiredPulse = pulse_q;

endmodule
